// File: rtl/enc42_seq.sv
// Sequential 4:2 priority encoder: accepts a 4-bit request vector and emits one
// beat per set bit (or a single zero beat) over a valid/ready stream.
module enc42_seq #(
    parameter bit PRIO_HIGH = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] D,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [1:0] Y,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       last,
    output logic       zero
);

    localparam int unsigned DW = 4;
    localparam int unsigned YW = 2;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [YW-1:0] y;
        logic          zero;
        logic          last;
    } beat_t;

    state_t        state;
    logic [DW-1:0] pend;
    logic [DW-1:0] pend_nxt;
    logic          in_hs;
    logic          out_hs;
    beat_t         beat_in;
    beat_t         beat_nx;

    // Beat presented for a pending-bit set: first set bit in scan order,
    // last when at most one bit remains, zero for an empty set.
    function automatic beat_t beat_of(input logic [DW-1:0] v);
        beat_t b;
        b = '0;
        if (v == '0) begin
            b.zero = 1'b1;
            b.last = 1'b1;
        end else begin
            if (PRIO_HIGH) begin
                for (int i = 0; i < int'(DW); i++) begin
                    if (v[i]) b.y = YW'(i);
                end
            end else begin
                for (int i = int'(DW) - 1; i >= 0; i--) begin
                    if (v[i]) b.y = YW'(i);
                end
            end
            b.last = ((v & (v - DW'(1))) == '0);
        end
        return b;
    endfunction

    assign in_ready = (state == IDLE) | (out_valid & out_ready & last);
    assign in_hs    = in_valid & in_ready;
    assign out_hs   = out_valid & out_ready;

    always_comb begin
        pend_nxt = pend & ~(DW'(1) << Y);
        beat_in  = beat_of(D);
        beat_nx  = beat_of(pend_nxt);
    end

    // A new accept takes precedence; it can only coincide with the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pend      <= '0;
            out_valid <= 1'b0;
            Y         <= '0;
            zero      <= 1'b0;
            last      <= 1'b0;
        end else if (in_hs) begin
            state     <= EMIT;
            pend      <= D;
            out_valid <= 1'b1;
            Y         <= beat_in.y;
            zero      <= beat_in.zero;
            last      <= beat_in.last;
        end else if (out_hs) begin
            if (last) begin
                state     <= IDLE;
                pend      <= '0;
                out_valid <= 1'b0;
                Y         <= '0;
                zero      <= 1'b0;
                last      <= 1'b0;
            end else begin
                pend <= pend_nxt;
                Y    <= beat_nx.y;
                zero <= beat_nx.zero;
                last <= beat_nx.last;
            end
        end
    end

endmodule

// File: tb/tb_enc42_seq.sv
// Bench for enc42_seq: both scan orders side by side, directed cases plus
// random traffic checked every cycle against a queue-of-beats model.
module tb_enc42_seq;

    logic       clk;
    logic       rst_n;
    logic [3:0] D;
    logic       in_valid;
    logic       out_ready;

    logic       h_in_ready, h_out_valid, h_last, h_zero;
    logic [1:0] h_y;
    logic       l_in_ready, l_out_valid, l_last, l_zero;
    logic [1:0] l_y;

    int vectors = 0;
    int miss    = 0;

    typedef struct packed {
        logic [1:0] y;
        logic       zero;
        logic       last;
    } exp_t;

    exp_t qh[$];
    exp_t ql[$];
    exp_t eh, el;
    logic ev, eir, mir;

    enc42_seq #(.PRIO_HIGH(1'b1)) dut_h (
        .clk(clk), .rst_n(rst_n), .D(D), .in_valid(in_valid), .in_ready(h_in_ready),
        .Y(h_y), .out_valid(h_out_valid), .out_ready(out_ready), .last(h_last), .zero(h_zero)
    );

    enc42_seq #(.PRIO_HIGH(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .D(D), .in_valid(in_valid), .in_ready(l_in_ready),
        .Y(l_y), .out_valid(l_out_valid), .out_ready(out_ready), .last(l_last), .zero(l_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Expand a vector into its beat list: set bits in scan order, or one zero beat.
    task automatic push_vec(input logic [3:0] d);
        int k;
        int n;
        exp_t b;
        k = $countones(d);
        if (k == 0) begin
            b.y = 2'd0; b.zero = 1'b1; b.last = 1'b1;
            qh.push_back(b);
            ql.push_back(b);
        end else begin
            n = 0;
            for (int i = 3; i >= 0; i--) begin
                if (d[i]) begin
                    n++;
                    b.y = 2'(i); b.zero = 1'b0; b.last = (n == k);
                    qh.push_back(b);
                end
            end
            n = 0;
            for (int i = 0; i < 4; i++) begin
                if (d[i]) begin
                    n++;
                    b.y = 2'(i); b.zero = 1'b0; b.last = (n == k);
                    ql.push_back(b);
                end
            end
        end
    endtask

    function automatic logic model_in_ready();
        return (qh.size() == 0) || (qh.size() == 1 && out_ready);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qh.delete();
            ql.delete();
        end else begin
            mir = model_in_ready();
            if (qh.size() != 0 && out_ready) begin
                void'(qh.pop_front());
                void'(ql.pop_front());
            end
            if (in_valid && mir) push_vec(D);
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        ev  = (qh.size() != 0);
        eir = model_in_ready();
        eh  = ev ? qh[0] : '0;
        el  = ev ? ql[0] : '0;
        chk("h_in_ready", int'(h_in_ready), int'(eir));
        chk("h_out_valid", int'(h_out_valid), int'(ev));
        chk("h_y", int'(h_y), int'(eh.y));
        chk("h_zero", int'(h_zero), int'(eh.zero));
        chk("h_last", int'(h_last), int'(eh.last));
        chk("l_in_ready", int'(l_in_ready), int'(eir));
        chk("l_out_valid", int'(l_out_valid), int'(ev));
        chk("l_y", int'(l_y), int'(el.y));
        chk("l_zero", int'(l_zero), int'(el.zero));
        chk("l_last", int'(l_last), int'(el.last));
    end

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // Present d with in_valid until the edge that accepts it (idle block).
    task automatic accept(input logic [3:0] d);
        edge1();
        D = d; in_valid = 1'b1; out_ready = 1'b1;
        edge1();
        in_valid = 1'b0;
    endtask

    logic [3:0] or_h, or_l;

    initial begin
        rst_n = 1'b0; D = '0; in_valid = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst_in_ready", int'(h_in_ready), 1);
        chk("rst_out_valid", int'(h_out_valid), 0);
        @(posedge clk); #3;
        rst_n = 1'b1;

        // 1010, both orders
        accept(4'b1010);
        @(negedge clk);
        chk("d28_h_y0", int'(h_y), 3); chk("d28_h_last0", int'(h_last), 0);
        chk("d33_l_y0", int'(l_y), 1); chk("d33_l_last0", int'(l_last), 0);
        @(negedge clk);
        chk("d28_h_y1", int'(h_y), 1); chk("d28_h_last1", int'(h_last), 1);
        chk("d33_l_y1", int'(l_y), 3); chk("d33_l_last1", int'(l_last), 1);
        @(negedge clk);
        chk("d28_idle", int'(h_out_valid), 0);

        // all-zero vector
        accept(4'b0000);
        @(negedge clk);
        chk("d29_zero", int'(h_zero), 1); chk("d29_last", int'(h_last), 1);
        chk("d29_y", int'(h_y), 0); chk("d29_in_ready", int'(h_in_ready), 1);
        @(negedge clk);
        chk("d29_idle", int'(h_out_valid), 0);

        // 1111 with out_ready toggling: each beat seen stalled, then taken
        accept(4'b1111);
        for (int i = 0; i < 4; i++) begin
            out_ready = 1'b0;
            @(negedge clk);
            chk("d30_y_stall", int'(h_y), 3 - i);
            chk("d30_last_stall", int'(h_last), int'(i == 3));
            edge1();
            out_ready = 1'b1;
            @(negedge clk);
            chk("d30_y_take", int'(h_y), 3 - i);
            chk("d30_last_take", int'(h_last), int'(i == 3));
            edge1();
        end
        @(negedge clk);
        chk("d30_idle", int'(h_out_valid), 0);

        // back-to-back 0001 then 0100
        edge1();
        D = 4'b0001; in_valid = 1'b1; out_ready = 1'b1;
        edge1();
        D = 4'b0100;
        @(negedge clk);
        chk("d31_y0", int'(h_y), 0); chk("d31_last0", int'(h_last), 1);
        chk("d31_in_ready", int'(h_in_ready), 1);
        edge1();
        in_valid = 1'b0;
        @(negedge clk);
        chk("d31_valid1", int'(h_out_valid), 1);
        chk("d31_y1", int'(h_y), 2); chk("d31_last1", int'(h_last), 1);
        @(negedge clk);
        chk("d31_idle", int'(h_out_valid), 0);

        // reset mid-emission
        accept(4'b1111);
        @(negedge clk);
        chk("d32_y0", int'(h_y), 3);
        @(negedge clk);
        chk("d32_y1", int'(h_y), 2);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("d32_rst_valid", int'(h_out_valid), 0);
        chk("d32_rst_y", int'(h_y), 0);
        chk("d32_rst_last", int'(h_last), 0);
        chk("d32_rst_in_ready", int'(h_in_ready), 1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("d32_no_residual", int'(h_out_valid), 0);
        end

        // exhaustive: OR of one-hot(Y) over the non-zero beats reproduces D
        for (int d = 0; d < 16; d++) begin
            accept(4'(d));
            or_h = '0; or_l = '0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (h_out_valid && !h_zero) or_h = or_h | (4'd1 << h_y);
                if (l_out_valid && !l_zero) or_l = or_l | (4'd1 << l_y);
            end
            chk("d33_or_h", int'(or_h), d);
            chk("d33_or_l", int'(or_l), d);
        end

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            edge1();
            in_valid  = ($urandom_range(0, 99) < 50);
            D         = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 99) < 70);
        end
        edge1();
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

endmodule
